// File: rtl/dist_id_ex_operand_stage.sv
// dist_id_ex_operand_stage: ID/EX distribution operand select, forwarding and distribution-use bubble insertion.
// Optional DIST_FWD_STATS_EN adds saturating forward/bubble counters.
`timescale 1ns/1ps
module dist_id_ex_operand_stage #(
  parameter int DIST_W = 32
`ifdef DIST_FWD_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_src_addr_i,
  input  logic [DIST_W-1:0] rf_ddata_i,
  input  logic              ex_dfwd_sel_i,
  input  logic              mem_dfwd_sel_i,
  input  logic [DIST_W-1:0] ex_dresult_i,
  input  logic              ex_dresult_valid_i,
  input  logic [DIST_W-1:0] mem_dresult_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  output logic              id_stall_o,
  output logic              ex_valid_o,
  output logic [4:0]        ex_src_addr_o,
  output logic [DIST_W-1:0] ex_ddata_o
`ifdef DIST_FWD_STATS_EN
  , output logic [STAT_W-1:0] stat_ex_fwd_o,
  output logic [STAT_W-1:0] stat_mem_fwd_o,
  output logic [STAT_W-1:0] stat_bubble_o
`endif
);
  typedef enum logic {RUN, BUBBLE} state_t;
  state_t state_q, state_d;
  logic ex_valid_q, ex_valid_d;
  logic [4:0] ex_src_addr_q, ex_src_addr_d;
  logic [DIST_W-1:0] ex_ddata_q, ex_ddata_d;
  logic addr_zero, hazard, bubble, hold;
  logic [DIST_W-1:0] operand;
  always_comb begin
    addr_zero = id_src_addr_i == 5'd0;
    operand = addr_zero ? '0 : ex_dfwd_sel_i ? ex_dresult_i : mem_dfwd_sel_i ? mem_dresult_i : rf_ddata_i;
    hazard = id_valid_i && !addr_zero && ex_dfwd_sel_i && !ex_dresult_valid_i;
    bubble = state_q == RUN && hazard;
    hold = ex_stall_i || bubble;
    state_d = flush_i ? RUN : ex_stall_i ? state_q : bubble ? BUBBLE : RUN;
    ex_valid_d = flush_i ? 1'b0 : ex_stall_i ? ex_valid_q : bubble ? 1'b0 : id_valid_i;
    ex_src_addr_d = flush_i ? 5'd0 : hold ? ex_src_addr_q : id_src_addr_i;
    ex_ddata_d = flush_i ? '0 : hold ? ex_ddata_q : operand;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      ex_valid_q <= 1'b0;
      ex_src_addr_q <= 5'd0;
      ex_ddata_q <= '0;
    end else begin
      state_q <= state_d;
      ex_valid_q <= ex_valid_d;
      ex_src_addr_q <= ex_src_addr_d;
      ex_ddata_q <= ex_ddata_d;
    end
  end
  assign id_stall_o = ex_stall_i || bubble;
  assign ex_valid_o = ex_valid_q;
  assign ex_src_addr_o = ex_src_addr_q;
  assign ex_ddata_o = ex_ddata_q;
`ifdef DIST_FWD_STATS_EN
  // A forward counts only when a real instruction is captured with that path selected.
  logic [STAT_W-1:0] ex_fwd_q, mem_fwd_q, bub_q;
  logic capture, inc_ex, inc_mem, inc_bub;
  always_comb begin
    capture = !flush_i && !hold;
    inc_ex = capture && id_valid_i && !addr_zero && ex_dfwd_sel_i;
    inc_mem = capture && id_valid_i && !addr_zero && !ex_dfwd_sel_i && mem_dfwd_sel_i;
    inc_bub = !flush_i && !ex_stall_i && bubble;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_fwd_q <= '0;
      mem_fwd_q <= '0;
      bub_q <= '0;
    end else begin
      if (inc_ex && ex_fwd_q != '1) ex_fwd_q <= ex_fwd_q + 1'b1;
      if (inc_mem && mem_fwd_q != '1) mem_fwd_q <= mem_fwd_q + 1'b1;
      if (inc_bub && bub_q != '1) bub_q <= bub_q + 1'b1;
    end
  end
  assign stat_ex_fwd_o = ex_fwd_q;
  assign stat_mem_fwd_o = mem_fwd_q;
  assign stat_bubble_o = bub_q;
`endif
endmodule

// File: tb/tb_dist_id_ex_operand_stage.sv
// tb_dist_id_ex_operand_stage: directed vectors with an expectation queue drained by a monitor.
`timescale 1ns/1ps
module tb_dist_id_ex_operand_stage;
  logic clk = 0, reset = 1;
  logic id_valid = 0, ex_dfwd_sel = 0, mem_dfwd_sel = 0, ex_dresult_valid = 0, ex_stall = 0, flush = 0;
  logic [4:0] id_src_addr = 0;
  logic [31:0] rf_ddata = 0, ex_dresult = 0, mem_dresult = 0;
  logic id_stall, ex_valid;
  logic [4:0] ex_src_addr;
  logic [31:0] ex_ddata;
  int checks = 0, errors = 0;
  typedef struct {logic v; logic [4:0] a; logic [31:0] d;} exp_t;
  exp_t oq[$];
  logic sq[$];
  always #5 clk = ~clk;
`ifdef DIST_FWD_STATS_EN
  logic [3:0] stat_ex_fwd, stat_mem_fwd, stat_bubble;
  dist_id_ex_operand_stage #(.DIST_W(32), .STAT_W(4)) dut (
`else
  dist_id_ex_operand_stage #(.DIST_W(32)) dut (
`endif
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_src_addr_i(id_src_addr),
    .rf_ddata_i(rf_ddata), .ex_dfwd_sel_i(ex_dfwd_sel), .mem_dfwd_sel_i(mem_dfwd_sel),
    .ex_dresult_i(ex_dresult), .ex_dresult_valid_i(ex_dresult_valid), .mem_dresult_i(mem_dresult),
    .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(id_stall), .ex_valid_o(ex_valid),
    .ex_src_addr_o(ex_src_addr), .ex_ddata_o(ex_ddata)
`ifdef DIST_FWD_STATS_EN
    , .stat_ex_fwd_o(stat_ex_fwd), .stat_mem_fwd_o(stat_mem_fwd), .stat_bubble_o(stat_bubble)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] rf, input logic es,
                      input logic [31:0] er, input logic erv, input logic ms, input logic [31:0] mr,
                      input logic st, input logic fl, input logic xs, input logic xv,
                      input logic [4:0] xa, input logic [31:0] xd);
    exp_t e;
    @(negedge clk);
    id_valid = v; id_src_addr = a; rf_ddata = rf; ex_dfwd_sel = es; ex_dresult = er;
    ex_dresult_valid = erv; mem_dfwd_sel = ms; mem_dresult = mr; ex_stall = st; flush = fl;
    e.v = xv; e.a = xa; e.d = xd;
    sq.push_back(xs);
    oq.push_back(e);
  endtask
  task automatic idle();
    id_valid = 0; id_src_addr = 0; rf_ddata = 0; ex_dfwd_sel = 0; mem_dfwd_sel = 0;
    ex_dresult_valid = 0; ex_stall = 0; flush = 0;
  endtask
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("id_stall", {31'd0, id_stall}, {31'd0, s});
      end
      @(posedge clk);
      #1;
      if (oq.size() > 0) begin
        e = oq.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        chk("ex_src_addr", {27'd0, ex_src_addr}, {27'd0, e.a});
        chk("ex_ddata", ex_ddata, e.d);
      end
    end
  end
  initial begin
    int wait_cycles;
    repeat (2) @(negedge clk);
    reset = 0;
    //   v  a      rf            es  ex_res      erv ms  mem_res     st fl  xs  xv xa     xd
    step(1, 5'd3, 32'hDEADBEEF, 0, 32'h0,      0,  0, 32'h0,      0, 0,  0,  1, 5'd3, 32'hDEADBEEF);
    step(1, 5'd5, 32'h0,        1, 32'h99,     0,  0, 32'h0,      0, 0,  1,  0, 5'd3, 32'hDEADBEEF);
    @(posedge clk);
    #3;
    idle();
    reset = 1;
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_ddata", ex_ddata, 32'd0);
    chk("rst_ex_src_addr", {27'd0, ex_src_addr}, 32'd0);
    @(negedge clk);
    reset = 0;
    step(1, 5'd5, 32'h0,        1, 32'h77,     0,  0, 32'h0,      0, 0,  1,  0, 5'd0, 32'h0);
    step(1, 5'd5, 32'h0,        0, 32'h0,      0,  1, 32'h22,     0, 0,  0,  1, 5'd5, 32'h22);
    step(1, 5'd5, 32'h0,        1, 32'h11,     1,  0, 32'h0,      0, 0,  0,  1, 5'd5, 32'h11);
    step(1, 5'd0, 32'h0,        1, 32'h33,     0,  0, 32'h0,      0, 0,  0,  1, 5'd0, 32'h0);
    step(1, 5'd7, 32'h44,       0, 32'h0,      0,  0, 32'h0,      1, 0,  1,  1, 5'd0, 32'h0);
    step(1, 5'd7, 32'h55,       0, 32'h0,      0,  0, 32'h0,      1, 0,  1,  1, 5'd0, 32'h0);
    step(1, 5'd7, 32'h55,       0, 32'h0,      0,  0, 32'h0,      1, 0,  1,  1, 5'd0, 32'h0);
    step(1, 5'd7, 32'h55,       0, 32'h0,      0,  0, 32'h0,      0, 0,  0,  1, 5'd7, 32'h55);
    step(1, 5'd9, 32'h0,        1, 32'h0,      0,  0, 32'h0,      0, 1,  1,  0, 5'd0, 32'h0);
    step(1, 5'd9, 32'h0,        1, 32'h0,      0,  0, 32'h0,      0, 0,  1,  0, 5'd0, 32'h0);
    step(1, 5'd9, 32'h0,        1, 32'hAB,     1,  0, 32'h0,      0, 0,  0,  1, 5'd9, 32'hAB);
    step(0, 5'd4, 32'h12,       0, 32'h0,      0,  0, 32'h0,      0, 0,  0,  0, 5'd4, 32'h12);
    step(1, 5'd6, 32'h13,       0, 32'h0,      0,  0, 32'h0,      1, 1,  1,  0, 5'd0, 32'h0);
    step(1, 5'd2, 32'h7,        1, 32'h5,      1,  1, 32'h6,      0, 0,  0,  1, 5'd2, 32'h5);
`ifdef DIST_FWD_STATS_EN
    @(posedge clk);
    #2;
    chk("stat_bubble", {28'd0, stat_bubble}, 32'd2);
    chk("stat_ex_fwd", {28'd0, stat_ex_fwd}, 32'd3);
    chk("stat_mem_fwd", {28'd0, stat_mem_fwd}, 32'd1);
    for (int i = 0; i < 16; i++)
      step(1, 5'd2, 32'h7,      1, 32'h5,      1,  0, 32'h0,      0, 0,  0,  1, 5'd2, 32'h5);
    @(posedge clk);
    #2;
    chk("stat_ex_fwd_sat", {28'd0, stat_ex_fwd}, 32'hF);
`endif
    @(negedge clk);
    idle();
    wait_cycles = 0;
    while ((sq.size() > 0 || oq.size() > 0) && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (sq.size() > 0 || oq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d stall and %0d output expectations left, expected 0", sq.size(), oq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
